// File: rtl/core_pkg.sv
// Shared types for the core memory arbiter: FSM state encoding and requester ids.
package core_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Requester identity; also the value held in last_id.
  typedef logic req_id_t;

  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave: the arbiter itself. master: the surrounding core and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction-fetch requester
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              i_if_kill;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  // Load/store requester
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [BE_W-1:0]   i_d_be;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  // External memory bus
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [BE_W-1:0]   o_mem_be;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_gnt;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_kill,
    output o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_be, i_d_wdata,
    output o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_kill,
    input  o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_be, i_d_wdata,
    input  o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on contention the
// requester that was not served last wins.
import core_pkg::*;

module rr_arb2 (
  input  logic    i_req_if,
  input  logic    i_req_d,
  input  req_id_t i_last_id,
  output logic    o_valid,
  output req_id_t o_id
);

  // Combinational winner selection.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_valid = i_req_if | i_req_d;
    o_id    = REQ_IF;
    if (i_req_if && i_req_d) begin
      o_id = (i_last_id == REQ_IF) ? REQ_D : REQ_IF;
    end else if (i_req_d) begin
      o_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store traffic onto one memory bus,
// one transaction at a time, with fetch-kill support for taken branches.
import core_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           i_reset_n,
  mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q,     state_d;
  req_id_t           winner_q,    winner_d;
  req_id_t           last_id_q,   last_id_d;
  logic              kill_q,      kill_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic              if_req_m;
  logic              d_req_m;
  logic              pick_valid;
  req_id_t           pick_id;
  logic              kill_hit;

  // A requester still seeing its response strobe is holding req from the
  // previous transaction; it is re-sampled only on the following cycle.
  assign if_req_m = bus.i_if_req & ~if_rvalid_q;
  assign d_req_m  = bus.i_d_req  & ~d_rvalid_q;

  rr_arb2 u_rr_arb2 (
    .i_req_if  (if_req_m),
    .i_req_d   (d_req_m),
    .i_last_id (last_id_q),
    .o_valid   (pick_valid),
    .o_id      (pick_id)
  );

  // Kill only matters while a fetch owns the bus.
  assign kill_hit = bus.i_if_kill && (winner_q == REQ_IF) && (state_q != IDLE);

  // Next-state and datapath: latch command in IDLE, hold it through REQ,
  // route the response in RESP.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_id_d   = last_id_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = REQ;
          winner_d  = pick_id;
          mem_req_d = 1'b1;
          if (pick_id == REQ_IF) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_if_addr;
            mem_be_d    = '1;
            mem_wdata_d = '0;
          end else begin
            mem_we_d    = bus.i_d_we;
            mem_addr_d  = bus.i_d_addr;
            mem_be_d    = bus.i_d_be;
            mem_wdata_d = bus.i_d_wdata;
          end
        end
      end

      REQ: begin
        if (kill_hit) kill_d = 1'b1;
        if (bus.i_mem_gnt) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end
      end

      RESP: begin
        if (kill_hit) kill_d = 1'b1;
        if (bus.i_mem_rvalid) begin
          state_d   = IDLE;
          last_id_d = winner_q;
          kill_d    = 1'b0;
          if (winner_q == REQ_IF) begin
            // A kill arriving together with the response still discards it.
            if (!(kill_q || bus.i_if_kill)) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = bus.i_mem_rdata;
            end
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? '0 : bus.i_mem_rdata;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any transaction.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      winner_q    <= REQ_IF;
      last_id_q   <= REQ_IF;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_id_q   <= last_id_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // All bus and response outputs come straight from flops.
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_d_rdata   = d_rdata_q;

  // Protocol checks: responses only in RESP; owners keep req until served.
  a_rvalid_in_resp: assert property (@(posedge clk) disable iff (!i_reset_n)
    bus.i_mem_rvalid |-> (state_q == RESP));

  a_if_req_held: assert property (@(posedge clk) disable iff (!i_reset_n)
    ((state_q != IDLE) && (winner_q == REQ_IF) && !kill_q && !bus.i_if_kill)
      |-> bus.i_if_req);

  a_d_req_held: assert property (@(posedge clk) disable iff (!i_reset_n)
    ((state_q != IDLE) && (winner_q == REQ_D)) |-> bus.i_d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model checks issued commands
// against an expected-command queue, and a monitor checks response strobes
// against per-requester expected-data queues.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic i_reset_n;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_len;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];

  int vectors     = 0;
  int miscompares = 0;

  int gnt_delay = 0;
  int rsp_delay = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h0000_0013;
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Memory model: grants after gnt_delay waiting cycles, answers rsp_delay
  // cycles after the grant, checks command contents and stability.
  initial begin
    int   req_len   = 0;
    bit   rsp_pend  = 0;
    int   rsp_wait  = 0;
    logic [31:0] rsp_data;
    logic [68:0] cap;
    cmd_t e;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      if (!i_reset_n) begin
        rsp_pend = 0;
        req_len  = 0;
      end else begin
        if (rsp_pend) begin
          rsp_wait--;
          if (rsp_wait == 0) begin
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = rsp_data;
            rsp_pend         = 0;
          end
        end
        if (bus.o_mem_req) begin
          if (req_len == 0)
            cap = {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_be, bus.o_mem_wdata};
          else
            check("cmd_stable", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_be, bus.o_mem_wdata}, cap);
          req_len++;
          if (req_len > gnt_delay) begin
            bus.i_mem_gnt = 1'b1;
            if (exp_cmd_q.size() == 0) begin
              check("mem_req_unexpected", bus.o_mem_req, 0);
            end else begin
              e = exp_cmd_q.pop_front();
              check("mem_we",    bus.o_mem_we,    e.we);
              check("mem_addr",  bus.o_mem_addr,  e.addr);
              check("mem_be",    bus.o_mem_be,    e.be);
              check("mem_wdata", bus.o_mem_wdata, e.wdata);
              check("mem_req_len", req_len, e.req_len);
            end
            rsp_pend = 1;
            rsp_wait = rsp_delay;
            rsp_data = bus.o_mem_we ? 32'hFFFF_FFFF : mem_rd(bus.o_mem_addr);
            req_len  = 0;
          end
        end
      end
    end
  end

  // Response monitor: every strobe must match the next expected datum.
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset_n) begin
        if (bus.o_if_rvalid) begin
          if (exp_if_q.size() == 0) check("if_rvalid_unexpected", bus.o_if_rvalid, 0);
          else                      check("if_rdata", bus.o_if_rdata, exp_if_q.pop_front());
        end
        if (bus.o_d_rvalid) begin
          if (exp_d_q.size() == 0) check("d_rvalid_unexpected", bus.o_d_rvalid, 0);
          else                     check("d_rdata", bus.o_d_rdata, exp_d_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Wait for a response strobe (is_if selects which); lat = negedges waited.
  task automatic wait_rvalid(input bit is_if, input int max, output int lat, output bit ok);
    ok  = 0;
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (is_if ? bus.o_if_rvalid : bus.o_d_rvalid) begin
        ok  = 1;
        lat = i;
        break;
      end
    end
    if (!ok) begin
      if (is_if) check("if_rvalid_timeout", bus.o_if_rvalid, 1);
      else       check("d_rvalid_timeout",  bus.o_d_rvalid,  1);
    end
  endtask

  task automatic if_txn(input logic [31:0] addr, input bit drop);
    int lat; bit ok;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = addr;
    wait_rvalid(1, 40, lat, ok);
    if (drop) bus.i_if_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input bit drop);
    int lat; bit ok;
    bus.i_d_req   = 1'b1;
    bus.i_d_we    = we;
    bus.i_d_addr  = addr;
    bus.i_d_be    = be;
    bus.i_d_wdata = wdata;
    wait_rvalid(0, 40, lat, ok);
    if (drop) bus.i_d_req = 1'b0;
  endtask

  task automatic wait_gnt();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (bus.i_mem_gnt) begin seen = 1; break; end
    end
    if (!seen) check("gnt_timeout", bus.o_mem_req, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"},   bus.o_mem_req,   0);
    check({tag, "_mem_we"},    bus.o_mem_we,    0);
    check({tag, "_mem_addr"},  bus.o_mem_addr,  0);
    check({tag, "_mem_be"},    bus.o_mem_be,    0);
    check({tag, "_mem_wdata"}, bus.o_mem_wdata, 0);
    check({tag, "_if_rvalid"}, bus.o_if_rvalid, 0);
    check({tag, "_if_rdata"},  bus.o_if_rdata,  0);
    check({tag, "_d_rvalid"},  bus.o_d_rvalid,  0);
    check({tag, "_d_rdata"},   bus.o_d_rdata,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset_n     = 1'b0;
    bus.i_if_req  = 1'b0;
    bus.i_if_kill = 1'b0;
    bus.i_d_req   = 1'b0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int lat; bit ok;
    i_reset_n     = 1'b0;
    bus.i_if_req  = 1'b0;
    bus.i_if_addr = '0;
    bus.i_if_kill = 1'b0;
    bus.i_d_req   = 1'b0;
    bus.i_d_we    = 1'b0;
    bus.i_d_addr  = '0;
    bus.i_d_be    = '0;
    bus.i_d_wdata = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;

    // Fetch 0x100, gnt immediate, data one cycle later: strobe in cycle 4.
    gnt_delay = 0; rsp_delay = 1;
    exp_cmd_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0, 1});
    exp_if_q.push_back(32'h0000_0013);
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h100;
    wait_rvalid(1, 20, lat, ok);
    if (ok) check("if_latency", lat + 1, 4);
    bus.i_if_req = 1'b0;

    // Store with delayed grant: REQ lasts 4 cycles, rdata forced to 0.
    gnt_delay = 3;
    exp_cmd_q.push_back('{1'b1, 32'h200, 4'h3, 32'hDEAD_BEEF, 4});
    exp_d_q.push_back(32'h0);
    @(negedge clk);
    d_txn(1'b1, 32'h200, 4'h3, 32'hDEAD_BEEF, 1);

    // Both requesting from reset: D, IF, D, IF.
    do_reset();
    gnt_delay = 0; rsp_delay = 1;
    exp_cmd_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0, 1});
    exp_cmd_q.push_back('{1'b0, 32'h500, 4'hF, 32'h0, 1});
    exp_cmd_q.push_back('{1'b0, 32'h404, 4'hF, 32'h0, 1});
    exp_cmd_q.push_back('{1'b0, 32'h504, 4'hF, 32'h0, 1});
    exp_d_q.push_back(32'hC0DE_0400);
    exp_d_q.push_back(32'hC0DE_0404);
    exp_if_q.push_back(32'hC0DE_0500);
    exp_if_q.push_back(32'hC0DE_0504);
    @(negedge clk);
    fork
      begin
        d_txn(1'b0, 32'h400, 4'hF, 32'h0, 0);
        d_txn(1'b0, 32'h404, 4'hF, 32'h0, 1);
      end
      begin
        if_txn(32'h500, 0);
        if_txn(32'h504, 1);
      end
    join

    // Kill during RESP of 0x104: bus completes, no strobe; 0x300 follows.
    rsp_delay = 2;
    exp_cmd_q.push_back('{1'b0, 32'h104, 4'hF, 32'h0, 1});
    exp_cmd_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0, 1});
    exp_if_q.push_back(32'hC0DE_0300);
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h104;
    wait_gnt();
    @(negedge clk);
    bus.i_if_kill = 1'b1;
    bus.i_if_addr = 32'h300;
    @(negedge clk);
    bus.i_if_kill = 1'b0;
    wait_rvalid(1, 20, lat, ok);
    bus.i_if_req = 1'b0;

    // Reset pulsed during RESP: outputs clear asynchronously.
    rsp_delay = 3;
    exp_cmd_q.push_back('{1'b0, 32'h108, 4'hF, 32'h0, 1});
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h108;
    wait_gnt();
    @(negedge clk);
    i_reset_n    = 1'b0;
    bus.i_if_req = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;

    // After reset: kill in IDLE is harmless, data wins first contention.
    rsp_delay = 1;
    exp_cmd_q.push_back('{1'b1, 32'h20C, 4'hC, 32'h1234_5678, 1});
    exp_cmd_q.push_back('{1'b0, 32'h10C, 4'hF, 32'h0, 1});
    exp_d_q.push_back(32'h0);
    exp_if_q.push_back(32'hC0DE_010C);
    @(negedge clk);
    bus.i_if_kill = 1'b1;
    fork
      begin
        @(negedge clk);
        bus.i_if_kill = 1'b0;
      end
      d_txn(1'b1, 32'h20C, 4'hC, 32'h1234_5678, 1);
      if_txn(32'h10C, 1);
    join

    repeat (4) @(negedge clk);
    check("exp_cmd_left", exp_cmd_q.size(), 0);
    check("exp_if_left",  exp_if_q.size(),  0);
    check("exp_d_left",   exp_d_q.size(),   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory bus between the instruction-fetch requester and the load/store requester of the core. Sits between `fetch`/`memaccess` and the external memory, serialising one transaction at a time with round-robin priority when both request together. Supports fetch-kill on a taken branch: in-flight fetches complete on the bus but their responses are discarded.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes

- `clk`  in  1  clock, rising edge
- `i_reset_n`  in  1  asynchronous active-low reset
- `i_if_req`  in  1  fetch request, held with `i_if_addr` until `o_if_rvalid`
- `i_if_addr`  in  ADDR_W  fetch address
- `i_if_kill`  in  1  discard the outstanding fetch response (branch taken)
- `o_if_rvalid`  out  1  one-cycle fetch response strobe
- `o_if_rdata`  out  DATA_W  fetch data, valid with `o_if_rvalid`
- `i_d_req`  in  1  data request, held with address/we/be/wdata until `o_d_rvalid`
- `i_d_we`  in  1  1 = store, 0 = load
- `i_d_addr`  in  ADDR_W  data address
- `i_d_be`  in  DATA_W/8  store byte enables
- `i_d_wdata`  in  DATA_W  store data
- `o_d_rvalid`  out  1  one-cycle data response strobe (loads and stores)
- `o_d_rdata`  out  DATA_W  load data; 0 for stores
- `o_mem_req`  out  1  bus request
- `o_mem_we`, `o_mem_addr`, `o_mem_be`, `o_mem_wdata`  out  1/ADDR_W/DATA_W/8/DATA_W  latched command; `be` all-ones for fetches
- `i_mem_gnt`  in  1  command accepted this cycle
- `i_mem_rvalid`  in  1  response (read data or write ack), exactly one per accepted command
- `i_mem_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: sample `i_if_req`/`i_d_req` (a requester whose `o_*_rvalid` is high this cycle is masked). If any, pick winner, latch its command and id into registers, go REQ.
- Pick: single requester wins; both → requester not served last (`last_id` register, reset = IF, so data wins first contention).
- REQ: `o_mem_req`=1, command stable from registers. On `i_mem_gnt` → RESP.
- RESP: wait `i_mem_rvalid`; on it, register `i_mem_rdata` to the winner's `o_*_rdata`, pulse winner's `o_*_rvalid` next cycle, update `last_id`, go IDLE.
- Kill: `i_if_kill` while winner=IF in REQ or RESP sets `kill_flag`; transaction completes on the bus (command never withdrawn), `o_if_rvalid` suppressed, `kill_flag` cleared on return to IDLE. Kill in IDLE, or with winner=D: no effect.
- Requester dropping `req` before its response is a protocol violation (assert in sim); arbiter ignores it.
- `o_d_rdata` forced 0 for store responses.

## Timing
- Reset (async, `i_reset_n` low): state IDLE, all outputs 0, `last_id`=IF, `kill_flag`=0.
- Minimum latency req→rvalid with gnt same cycle as `o_mem_req` and rvalid the cycle after gnt: 4 cycles (sample, REQ, RESP, rvalid strobe).
- `o_mem_req` is a pure register output; no combinational path from requester inputs to bus outputs.
- `i_mem_rvalid` while not in RESP: ignored (sim assertion).
- Back-to-back: requester may hold req through its rvalid cycle; re-sampled the following cycle.
- Reset asserted mid-transaction: immediate return to IDLE, pending response lost; memory side must be reset together.

## Structure
- `core_pkg`: `arb_state_t` enum (IDLE/REQ/RESP), requester id constants `REQ_IF`=0, `REQ_D`=1.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick from two request bits and `last_id`; FSM and datapath registers stay in `mem_arbiter`.

## Test plan
- Fetch only, addr 0x100, mem returns 0x00000013 one cycle after gnt → `o_mem_addr`=0x100, be=0xF, `o_if_rvalid` pulse with 0x00000013, 4 cycles after req.
- Store addr 0x200, be=0x3, wdata 0xDEADBEEF, gnt delayed 3 cycles → command stable throughout REQ, `o_d_rvalid` pulse, `o_d_rdata`=0.
- Both requesting continuously from reset → grants alternate D, IF, D, IF; neither starves.
- `i_if_kill` during RESP of fetch 0x104 → bus completes, no `o_if_rvalid`; next fetch 0x300 served normally.
- `i_reset_n` pulsed low in RESP → all outputs 0 asynchronously, FSM IDLE, new request after reset served correctly.
